mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the Riviera RV64 pipeline; sits between `ex_stage` and the WB stage. It consumes the EX→MEM `interconnection_struct`, performs loads/stores against the data-memory port through a request/grant/rvalid handshake, and forwards results to WB. It drives the back-pressure (`o_mem_ready`) and the in-flight destination register (`o_mem_rd`) that EX's stall controller consumes.

## Interface
- Parameters: none; widths come from `` `ALEN `` (64) and `` `RNG_64 ``.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_ex2all`  in  `interconnection_struct`  EX result.
  - Uses `is_valid`, `rf_wr_en`, `rf_wr_addr`, `alu_result` (effective address for memory ops), `mem_rd_en`, `mem_wr_en`, `mem_size` (0=B, 1=H, 2=W, 3=D), `mem_unsigned`, `store_data`.
- `o_mem_ready`  out  1  MEM can accept `i_ex2all` this cycle.
- `o_mem_rd`  out  `ALEN`  `rf_wr_addr` of instruction held in MEM, 0 if none or `rf_wr_en`=0.
- `o_mem2wb`  out  `interconnection_struct`  result to WB; `rf_wr_data` holds load data or `alu_result`.
- `o_misaligned`  out  1  one-cycle pulse: dropped misaligned access.
- `o_dmem_req`  out  1  data-memory request.
- `o_dmem_we`  out  1  1=store.
- `o_dmem_addr`  out  `ALEN`  doubleword-aligned address (bits[2:0]=0).
- `o_dmem_be`  out  8  byte enables.
- `o_dmem_wdata`  out  64  store data on byte lanes.
- `i_dmem_gnt`  in  1  request accepted this cycle.
- `i_dmem_rvalid`  in  1  read data valid.
- `i_dmem_rdata`  in  64  read data.

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE: `o_mem_ready`=1. On accept (`i_ex2all.is_valid`):
  - Non-memory op: registered straight to `o_mem2wb` next cycle with `rf_wr_data`=`alu_result`; stay IDLE.
  - Aligned memory op: latch the op; go to REQ.
  - Misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0): no memory request; `o_misaligned` pulses next cycle; `o_mem2wb` carries the op with `rf_wr_en` forced 0; stay IDLE.
- REQ: `o_dmem_req`=1. Addr/be/wdata/we are held stable until `i_dmem_gnt`.
  - Store with gnt: `o_mem2wb` valid next cycle; go to IDLE.
  - Load with gnt: go to WAIT_R.
- WAIT_R: wait for `i_dmem_rvalid`. Then select lane by addr[2:0], sign- or zero-extend per `mem_size`/`mem_unsigned`, and register into `o_mem2wb.rf_wr_data`; go to IDLE.
- `i_dmem_rvalid` outside WAIT_R is ignored.
- Byte enables: B = `1<<a`, H = `3<<a`, W = `15<<a`, D = `0xFF` (a = addr[2:0]). Store data is replicated across lanes (B×8, H×4, W×2).
- `o_mem2wb.is_valid`=0 in every cycle no instruction completes (bubble).
- `o_mem_rd` stays valid from the cycle after accept until the cycle the result leaves to WB.

## Timing
- Reset: state IDLE; `o_mem2wb`=0, `o_mem_rd`=0, `o_dmem_req`=0, `o_dmem_we`=0, `o_dmem_addr`/`be`/`wdata`=0, `o_misaligned`=0. `o_mem_ready`=1 after reset.
- `o_mem_ready` is combinational: 1 only in IDLE. It is low through REQ/WAIT_R.
- Non-memory op: 1-cycle latency; full throughput (one per cycle).
- Load, gnt on first REQ cycle, rvalid one cycle later: accept at T0, req at T1, rvalid at T2, `o_mem2wb` at T3. Each gnt or rvalid wait cycle adds one cycle.
- Store: accept T0, req+gnt T1, `o_mem2wb` T2.
- rvalid in the same cycle as gnt is not legal (earliest is gnt+1).
- Async reset mid-transaction drops `o_dmem_req` immediately and discards the latched op. Any late rvalid is ignored.

## Structure
- Shared package: the added `interconnection_struct` fields (`mem_rd_en`, `mem_wr_en`, `mem_size`, `mem_unsigned`, `store_data`, `rf_wr_data`), a `mem_size_e` enum, and the FSM state enum.
- Sub-module `mem_lsu_align` (combinational): be/wdata generation and load lane extraction/extension. FSM and registers stay in `mem_stage`.

## Test plan
- LW at 0x1004, rdata=0x8000_0000_xxxx_xxxx, gnt immediate, rvalid+1 → be=0xF0 on the request; WB data 0xFFFF_FFFF_8000_0000 at T3; `o_mem_ready` low T1–T2.
- SB 0xAB at 0x2003, gnt delayed 3 cycles → req held 4 cycles with be=0x08, wdata=0xABAB…AB stable; WB bubble-free completion the cycle after gnt.
- LHU at 0x3006, rdata[63:48]=0xF00D → WB data 0x0000…F00D.
- LD at 0x4004 → no `o_dmem_req`; `o_misaligned` pulse; `o_mem2wb.rf_wr_en`=0.
- 5 back-to-back ADDs with rd=5..9 → one WB result per cycle; `o_mem_rd` tracks 5..9 with 1-cycle lag.
- `rst_n` low during WAIT_R, then rvalid → outputs zero, state IDLE, rvalid ignored, `o_mem_ready`=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------+
// | mem_stage_pkg : shared types for the Riviera RV64 MEM stage           |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

    localparam int ALEN = 64;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic            is_valid;
        logic            rf_wr_en;
        logic [4:0]      rf_wr_addr;
        logic [ALEN-1:0] alu_result;
        logic            mem_rd_en;
        logic            mem_wr_en;
        mem_size_e       mem_size;
        logic            mem_unsigned;
        logic [63:0]     store_data;
        logic [63:0]     rf_wr_data;
    } interconnection_struct;

    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = addr_lo[0];
            MEM_W:   mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// +----------------------------------------------------------------------+
// | mem_lsu_align : byte-enable / store-lane generation and load extract  |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  mem_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [63:0] i_store_data,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata,
    output logic [63:0] o_load_data
);

    logic [63:0] w_lane;

    // Bring the addressed bytes down to bit 0 before extension.
    assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be        = 8'hFF;
        o_wdata     = i_store_data;
        o_load_data = w_lane;
        case (i_size)
            MEM_B: begin
                o_be        = 8'h01 << i_addr_lo;
                o_wdata     = {8{i_store_data[7:0]}};
                o_load_data = {{56{w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            end
            MEM_H: begin
                o_be        = 8'h03 << i_addr_lo;
                o_wdata     = {4{i_store_data[15:0]}};
                o_load_data = {{48{w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            end
            MEM_W: begin
                o_be        = 8'h0F << i_addr_lo;
                o_wdata     = {2{i_store_data[31:0]}};
                o_load_data = {{32{w_lane[31] & ~i_unsigned}}, w_lane[31:0]};
            end
            default: begin
                o_be        = 8'hFF;
                o_wdata     = i_store_data;
                o_load_data = w_lane;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage : RV64 memory-access stage with req/gnt/rvalid data port    |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  interconnection_struct i_ex2all,
    output logic                 o_mem_ready,
    output logic [ALEN-1:0]      o_mem_rd,
    output interconnection_struct o_mem2wb,
    output logic                 o_misaligned,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [ALEN-1:0]      o_dmem_addr,
    output logic [7:0]           o_dmem_be,
    output logic [63:0]          o_dmem_wdata,
    input  logic                 i_dmem_gnt,
    input  logic                 i_dmem_rvalid,
    input  logic [63:0]          i_dmem_rdata
);

    mem_state_e           state_q, state_d;
    interconnection_struct op_q, op_d;
    interconnection_struct out_q, out_d;
    logic                 misaligned_q, misaligned_d;

    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [63:0] w_load_data;
    logic        w_is_mem;
    logic        w_req;

    mem_lsu_align u_align (
        .i_addr_lo    (op_q.alu_result[2:0]),
        .i_size       (op_q.mem_size),
        .i_unsigned   (op_q.mem_unsigned),
        .i_store_data (op_q.store_data),
        .i_rdata      (i_dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign w_is_mem = i_ex2all.mem_rd_en | i_ex2all.mem_wr_en;
    assign w_req    = (state_q == ST_REQ);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        out_d        = '0;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ex2all.is_valid) begin
                    if (!w_is_mem) begin
                        out_d            = i_ex2all;
                        out_d.rf_wr_data = i_ex2all.alu_result;
                    end else if (is_misaligned(i_ex2all.mem_size, i_ex2all.alu_result[2:0])) begin
                        // Dropped access still retires so WB sees the instruction.
                        out_d            = i_ex2all;
                        out_d.rf_wr_en   = 1'b0;
                        out_d.rf_wr_data = i_ex2all.alu_result;
                        misaligned_d     = 1'b1;
                    end else begin
                        op_d    = i_ex2all;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    if (op_q.mem_wr_en) begin
                        out_d            = op_q;
                        out_d.rf_wr_data = op_q.alu_result;
                        state_d          = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                if (i_dmem_rvalid) begin
                    out_d            = op_q;
                    out_d.rf_wr_data = w_load_data;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            out_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            out_q        <= out_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Port fields are gated by the request so they read zero whenever idle.
    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_req & op_q.mem_wr_en;
    assign o_dmem_addr  = w_req ? {op_q.alu_result[ALEN-1:3], 3'b000} : '0;
    assign o_dmem_be    = w_req ? w_be : 8'h00;
    assign o_dmem_wdata = (w_req && op_q.mem_wr_en) ? w_wdata : 64'd0;

    assign o_mem_ready  = (state_q == ST_IDLE);
    assign o_mem2wb     = out_q;
    assign o_misaligned = misaligned_q;

    always_comb begin
        o_mem_rd = '0;
        if (state_q != ST_IDLE) begin
            if (op_q.rf_wr_en) o_mem_rd = {{(ALEN-5){1'b0}}, op_q.rf_wr_addr};
        end else if (out_q.is_valid && out_q.rf_wr_en) begin
            o_mem_rd = {{(ALEN-5){1'b0}}, out_q.rf_wr_addr};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------+
// | tb_mem_stage : directed + randomized bench for mem_stage              |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                  clk;
    logic                  rst_n;
    interconnection_struct ex;
    logic                  mem_ready;
    logic [ALEN-1:0]       mem_rd;
    interconnection_struct mem2wb;
    logic                  misaligned;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ALEN-1:0]       dmem_addr;
    logic [7:0]            dmem_be;
    logic [63:0]           dmem_wdata;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [63:0]           dmem_rdata;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ex2all      (ex),
        .o_mem_ready   (mem_ready),
        .o_mem_rd      (mem_rd),
        .o_mem2wb      (mem2wb),
        .o_misaligned  (misaligned),
        .o_dmem_req    (dmem_req),
        .o_dmem_we     (dmem_we),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_be     (dmem_be),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_gnt    (dmem_gnt),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: lane mask, replication and extension by plain arithmetic.
    function automatic logic [7:0] ref_be(input int nb, input int a);
        return 8'(((1 << nb) - 1) << a);
    endfunction

    function automatic logic [63:0] ref_wdata(input int nb, input logic [63:0] sd);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] ref_load(input int nb, input int a, input logic uns,
                                             input logic [63:0] rdata);
        logic [63:0] v;
        logic [63:0] mask;
        int          bits;
        bits = 8 * nb;
        v    = rdata >> (8 * a);
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v    = v & mask;
            if (!uns && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic run_op(input interconnection_struct op, input int gdel, input int rdel,
                          input logic [63:0] rdata, input string tag);
        int          nb;
        int          a;
        logic        is_mem;
        logic        mis;
        logic [63:0] exp_rd;
        nb     = 1 << int'(op.mem_size);
        a      = int'(op.alu_result[2:0]);
        is_mem = op.mem_rd_en | op.mem_wr_en;
        mis    = is_mem && ((op.alu_result % 64'(nb)) != 64'd0);
        exp_rd = op.rf_wr_en ? 64'(op.rf_wr_addr) : 64'd0;

        chk({tag, ".ready0"}, 64'(mem_ready), 64'd1);
        ex = op;
        tick();
        ex = '0;
        if (!is_mem || mis) begin
            chk({tag, ".wb_valid"}, 64'(mem2wb.is_valid), 64'd1);
            chk({tag, ".wb_wren"}, 64'(mem2wb.rf_wr_en), mis ? 64'd0 : 64'(op.rf_wr_en));
            chk({tag, ".wb_data"}, mem2wb.rf_wr_data, op.alu_result);
            chk({tag, ".misal"}, 64'(misaligned), 64'(mis));
            chk({tag, ".noreq"}, 64'(dmem_req), 64'd0);
            if (!is_mem) chk({tag, ".rd"}, mem_rd, exp_rd);
            return;
        end
        for (int k = 0; k <= gdel; k++) begin
            chk({tag, ".req"}, 64'(dmem_req), 64'd1);
            chk({tag, ".ready_req"}, 64'(mem_ready), 64'd0);
            chk({tag, ".we"}, 64'(dmem_we), 64'(op.mem_wr_en));
            chk({tag, ".addr"}, dmem_addr, op.alu_result & ~64'd7);
            chk({tag, ".be"}, 64'(dmem_be), 64'(ref_be(nb, a)));
            if (op.mem_wr_en) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(nb, op.store_data));
            chk({tag, ".rd_req"}, mem_rd, exp_rd);
            chk({tag, ".bubble_req"}, 64'(mem2wb.is_valid), 64'd0);
            if (k == gdel) dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
        end
        if (!op.mem_wr_en) begin
            for (int k = 0; k <= rdel; k++) begin
                chk({tag, ".noreq_wait"}, 64'(dmem_req), 64'd0);
                chk({tag, ".ready_wait"}, 64'(mem_ready), 64'd0);
                chk({tag, ".rd_wait"}, mem_rd, exp_rd);
                chk({tag, ".bubble_wait"}, 64'(mem2wb.is_valid), 64'd0);
                if (k == rdel) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
                tick();
                dmem_rvalid = 1'b0;
                dmem_rdata  = {$urandom, $urandom};
            end
        end
        chk({tag, ".done_valid"}, 64'(mem2wb.is_valid), 64'd1);
        chk({tag, ".done_wren"}, 64'(mem2wb.rf_wr_en), 64'(op.rf_wr_en));
        chk({tag, ".done_data"}, mem2wb.rf_wr_data,
            op.mem_wr_en ? op.alu_result : ref_load(nb, a, op.mem_unsigned, rdata));
        chk({tag, ".done_noreq"}, 64'(dmem_req), 64'd0);
        chk({tag, ".done_ready"}, 64'(mem_ready), 64'd1);
    endtask

    function automatic interconnection_struct mk(input logic rd_en, input logic wr_en,
                                                 input mem_size_e sz, input logic uns,
                                                 input logic [63:0] addr, input logic [63:0] sd,
                                                 input logic [4:0] rd);
        interconnection_struct o;
        o              = '0;
        o.is_valid     = 1'b1;
        o.rf_wr_en     = ~wr_en;
        o.rf_wr_addr   = rd;
        o.alu_result   = addr;
        o.mem_rd_en    = rd_en;
        o.mem_wr_en    = wr_en;
        o.mem_size     = sz;
        o.mem_unsigned = uns;
        o.store_data   = sd;
        return o;
    endfunction

    initial begin
        interconnection_struct op;
        logic [1:0]  sz;
        logic [63:0] addr;
        int          kind;

        ex          = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        rst_n       = 1'b0;
        repeat (3) tick();
        chk("rst.ready", 64'(mem_ready), 64'd1);
        chk("rst.wb", 64'(mem2wb), 64'd0);
        chk("rst.rd", mem_rd, 64'd0);
        chk("rst.req", 64'(dmem_req), 64'd0);
        chk("rst.be", 64'(dmem_be), 64'd0);
        chk("rst.addr", dmem_addr, 64'd0);
        chk("rst.misal", 64'(misaligned), 64'd0);
        rst_n = 1'b1;
        tick();

        // LW at 0x1004: upper word sign-extended.
        run_op(mk(1, 0, MEM_W, 0, 64'h1004, 0, 5'd3), 0, 0, 64'h8000_0000_1234_5678, "lw");
        chk("lw.value", mem2wb.rf_wr_data, 64'hFFFF_FFFF_8000_0000);
        // SB with a three-cycle grant delay.
        run_op(mk(0, 1, MEM_B, 0, 64'h2003, 64'hAB, 5'd0), 3, 0, 0, "sb");
        run_op(mk(1, 0, MEM_H, 1, 64'h3006, 0, 5'd4), 1, 2, 64'hF00D_1111_2222_3333, "lhu");
        chk("lhu.value", mem2wb.rf_wr_data, 64'h0000_0000_0000_F00D);
        run_op(mk(1, 0, MEM_D, 0, 64'h4004, 0, 5'd7), 0, 0, 0, "ld_mis");
        tick();
        chk("mis.pulse_end", 64'(misaligned), 64'd0);

        // Back-to-back ALU ops, one retirement per cycle.
        for (int r = 5; r <= 9; r++) begin
            op = mk(0, 0, MEM_B, 0, 64'(r * 100), 0, 5'(r));
            run_op(op, 0, 0, 0, "add");
        end
        tick();
        chk("add.bubble", 64'(mem2wb.is_valid), 64'd0);
        chk("add.rd_clear", mem_rd, 64'd0);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            op = mk(kind == 1, kind == 2, mem_size_e'(sz), 1'($urandom_range(0, 1)), addr,
                    {$urandom, $urandom}, 5'($urandom));
            if (kind == 0) op.rf_wr_en = 1'($urandom_range(0, 1));
            run_op(op, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, "rnd");
            if ($urandom_range(0, 4) == 0) begin
                dmem_rvalid = 1'b1;
                tick();
                dmem_rvalid = 1'b0;
                chk("rnd.idle_bubble", 64'(mem2wb.is_valid), 64'd0);
            end
        end

        // Async reset while waiting for read data.
        op = mk(1, 0, MEM_D, 0, 64'h5000, 0, 5'd12);
        ex = op;
        tick();
        ex = '0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rstw.in_wait", 64'(mem_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw.req", 64'(dmem_req), 64'd0);
        chk("rstw.ready", 64'(mem_ready), 64'd1);
        chk("rstw.rd", mem_rd, 64'd0);
        chk("rstw.wb", 64'(mem2wb), 64'd0);
        #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hDEAD_BEEF_0000_0001;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstw.late_rvalid", 64'(mem2wb.is_valid), 64'd0);
        chk("rstw.ready_after", 64'(mem_ready), 64'd1);
        chk("rstw.req_after", 64'(dmem_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
